// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - signed 32x32 radix-2 Booth multiplier sequencer with its add_32 adder
// One add/sub per cycle for 32 cycles; result published on hi/lo with a one-cycle done pulse.

module add_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s
);
    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [31:0] w_c;
    logic [6:0]  w_gg;
    logic [6:0]  w_gp;
    logic [7:0]  w_gc;

    // 4-bit lookahead groups chained by group generate/propagate
    always_comb begin
        w_g  = a & b;
        w_p  = a ^ b;
        w_gg = '0;
        w_gp = '0;
        w_gc = '0;
        w_c  = '0;
        w_gc[0] = cin;
        for (int grp = 0; grp < 7; grp++) begin
            w_gg[grp] = w_g[4*grp+3]
                      | (w_p[4*grp+3] & w_g[4*grp+2])
                      | (w_p[4*grp+3] & w_p[4*grp+2] & w_g[4*grp+1])
                      | (w_p[4*grp+3] & w_p[4*grp+2] & w_p[4*grp+1] & w_g[4*grp]);
            w_gp[grp] = &w_p[4*grp +: 4];
            w_gc[grp+1] = w_gg[grp] | (w_gp[grp] & w_gc[grp]);
        end
        for (int grp = 0; grp < 8; grp++) begin
            w_c[4*grp]   = w_gc[grp];
            w_c[4*grp+1] = w_g[4*grp] | (w_p[4*grp] & w_gc[grp]);
            w_c[4*grp+2] = w_g[4*grp+1]
                         | (w_p[4*grp+1] & w_g[4*grp])
                         | (w_p[4*grp+1] & w_p[4*grp] & w_gc[grp]);
            w_c[4*grp+3] = w_g[4*grp+2]
                         | (w_p[4*grp+2] & w_g[4*grp+1])
                         | (w_p[4*grp+2] & w_p[4*grp+1] & w_g[4*grp])
                         | (w_p[4*grp+2] & w_p[4*grp+1] & w_p[4*grp] & w_gc[grp]);
        end
        s = w_p ^ w_c;
    end
endmodule

module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [31:0] r_m;
    logic [31:0] r_a;
    logic [31:0] r_q;
    logic        r_q1;
    logic [4:0]  r_cnt;

    logic        w_op_add;
    logic        w_op_sub;
    logic        w_use_sum;
    logic [31:0] w_rb;
    logic [31:0] w_sum;
    logic [31:0] w_s;
    logic        w_ovf;
    logic        w_sgn;
    logic [31:0] w_a_nx;
    logic [31:0] w_q_nx;

    assign w_op_add  = ~r_q[0] &  r_q1;
    assign w_op_sub  =  r_q[0] & ~r_q1;
    assign w_use_sum = w_op_add | w_op_sub;
    assign w_rb      = w_op_sub ? ~r_m : r_m;

    add_32 u_add (
        .a   (r_a),
        .b   (w_rb),
        .cin (w_op_sub),
        .s   (w_sum)
    );

    // The 33rd bit is recovered from overflow so M = -2^31 still shifts in the right sign
    assign w_s    = w_use_sum ? w_sum : r_a;
    assign w_ovf  = w_use_sum && (r_a[31] == w_rb[31]) && (w_sum[31] != r_a[31]);
    assign w_sgn  = w_s[31] ^ w_ovf;
    assign w_a_nx = {w_sgn, w_s[31:1]};
    assign w_q_nx = {w_s[0], r_q[31:1]};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
            r_m     <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            if (r_state == S_RUN) begin
                r_a   <= w_a_nx;
                r_q   <= w_q_nx;
                r_q1  <= r_q[0];
                r_cnt <= r_cnt + 5'd1;
                if (r_cnt == 5'd31) begin
                    r_state <= S_DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    hi      <= w_a_nx;
                    lo      <= w_q_nx;
                end
            end else if (start) begin
                r_state <= S_RUN;
                r_m     <= a;
                r_q     <= b;
                r_a     <= '0;
                r_q1    <= 1'b0;
                r_cnt   <= '0;
                busy    <= 1'b1;
            end else begin
                r_state <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb/tb_booth_mul_seq.sv - directed and random checks for booth_mul_seq

module tb_booth_mul_seq;
    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    booth_mul_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] ehi;
        logic [31:0] elo;
        bit          glitch;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // glitch: change a/b before T1 and pulse start into edges T5 and T20
    task automatic mul_op(input logic [31:0] ta, input logic [31:0] tb, input bit glitch,
                          output logic [31:0] rhi, output logic [31:0] rlo,
                          output int lat, output int bsy, output int both);
        rhi = 'x;
        rlo = 'x;
        @(posedge clk); #1;
        a = ta;
        b = tb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        bsy = 0;
        both = 0;
        if (busy) bsy++;
        for (int k = 1; k <= 40; k++) begin
            if (glitch) begin
                if (k == 1) begin
                    a = $urandom;
                    b = $urandom;
                end
                start = (k == 5 || k == 20);
            end
            @(posedge clk); #1;
            if (busy && done) both++;
            if (done) begin
                lat = k;
                rhi = hi;
                rlo = lo;
                break;
            end
            if (busy) bsy++;
        end
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] rhi, rlo;
        int lat, bsy, both, dcount, c1, c2;
        longint prod;

        vecs[0]  = '{32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1'b0};
        vecs[1]  = '{32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b1};
        vecs[2]  = '{32'hFFFFFFF9, 32'hFFFFFFFA, 32'h00000000, 32'h0000002A, 1'b0};
        vecs[3]  = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b1};
        vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[5]  = '{32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        vecs[6]  = '{32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[7]  = '{32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[8]  = '{32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0};
        vecs[9]  = '{32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0};
        vecs[10] = '{32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[11] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};

        #3;
        chk("reset_outputs", {28'd0, busy, done, |hi, |lo}, 64'd0);
        @(posedge clk); #1;
        clr_n = 1'b1;

        foreach (vecs[i]) begin
            mul_op(vecs[i].va, vecs[i].vb, vecs[i].glitch, rhi, rlo, lat, bsy, both);
            chk($sformatf("vec%0d_product", i), {rhi, rlo}, {vecs[i].ehi, vecs[i].elo});
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
            chk($sformatf("vec%0d_busy_cycles", i), 64'(bsy), 64'd32);
            chk($sformatf("vec%0d_busy_and_done", i), 64'(both), 64'd0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_after_done", i), {62'd0, busy, done}, 64'd0);
        end

        // Asynchronous reset ten cycles into an operation
        @(posedge clk); #1;
        a = 32'd12;
        b = 32'd12;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        clr_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", {busy, done, hi, lo}, 66'd0);
        @(posedge clk); #1;
        clr_n = 1'b1;
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy) dcount++;
        end
        chk("no_done_after_abort", 64'(dcount), 64'd0);
        mul_op(32'd3, 32'd5, 1'b0, rhi, rlo, lat, bsy, both);
        chk("post_reset_3x5", {rhi, rlo}, 64'd15);
        chk("post_reset_latency", 64'(lat), 64'd32);

        // Back-to-back with start held high
        @(posedge clk); #1;
        a = 32'hFFFFFFFF;
        b = 32'hFFFFFFFF;
        start = 1'b1;
        @(posedge clk); #1;
        a = 32'h12345678;
        b = 32'h00000010;
        c1 = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                c1 = cyc;
                chk("b2b_first", {hi, lo}, 64'd1);
                break;
            end
        end
        chk("b2b_first_seen", 64'(c1 >= 0), 64'd1);
        @(posedge clk); #1;
        chk("b2b_busy_adjacent", {63'd0, busy}, 64'd1);
        start = 1'b0;
        c2 = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                c2 = cyc;
                chk("b2b_second", {hi, lo}, 64'h00000001_23456780);
                break;
            end
        end
        chk("b2b_spacing", 64'(c2 - c1), 64'd33);

        // Random signed operands against a 64-bit reference product
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            mul_op(ra, rb, 1'b0, rhi, rlo, lat, bsy, both);
            prod = longint'($signed(ra)) * longint'($signed(rb));
            chk($sformatf("rand%0d_%h_%h", i, ra, rb), {rhi, rlo}, prod);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end
endmodule
